freq_meter: RTL and testbench

- Measures the frequency of an external square-wave signal against the system clock, e.g. the 1 Hz output of the team's clock divider or any slow on-board signal.
- Counts rising edges of the synchronized input over a fixed gate window of GATE_CYCLES clocks.
- Publishes the count as the measured frequency, with a one-cycle valid strobe.
- Sits downstream of clock/tick generators and serves as the bench and self-check for them.

---
 rtl/freq_meter.sv | 76 +++++++
 tb/tb_freq_meter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: counts synchronized sig_in rising edges over a GATE_CYCLES window and publishes the count.
module freq_meter #(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int GATE_CYCLES = CLK_FREQ,
  parameter int COUNT_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               sig_in,
  output logic [COUNT_W-1:0] freq_out,
  output logic               freq_valid,
  output logic               overflow,
  output logic               gate_active
);
  localparam int GW = $clog2(GATE_CYCLES);
  localparam logic [1:0] IDLE = 2'd0, GATE = 2'd1, LATCH = 2'd2;
  logic [1:0] state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic sync_d, rise, at_max, sat, sat_nxt, last;
  logic [GW-1:0] gate_cnt;
  logic [COUNT_W-1:0] edge_cnt, cnt_nxt;
  assign rise = sync_q[SYNC_STAGES-1] & ~sync_d;
  assign at_max = &edge_cnt;
  assign cnt_nxt = edge_cnt + COUNT_W'(rise & ~at_max);
  // sat records an edge lost because the counter was already full
  assign sat_nxt = sat | (rise & at_max);
  assign last = gate_cnt == GW'(GATE_CYCLES - 1);
  assign gate_active = state == GATE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sync_q <= '0;
      sync_d <= 1'b0;
      gate_cnt <= '0;
      edge_cnt <= '0;
      sat <= 1'b0;
      freq_out <= '0;
      freq_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      sync_d <= sync_q[SYNC_STAGES-1];
      freq_valid <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= GATE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat <= 1'b0;
        end
        GATE: if (!enable) state <= IDLE;
        else begin
          gate_cnt <= gate_cnt + GW'(1);
          edge_cnt <= cnt_nxt;
          sat <= sat_nxt;
          // publish on the final gate cycle so the result and strobe appear together in LATCH
          if (last) begin
            state <= LATCH;
            freq_out <= cnt_nxt;
            overflow <= sat_nxt;
            freq_valid <= 1'b1;
          end
        end
        LATCH: begin
          state <= enable ? GATE : IDLE;
          gate_cnt <= '0;
          edge_cnt <= '0;
          sat <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: two freq_meter instances checked every cycle against a window-level model.
module tb_freq_meter;
  logic clk, reset, enable, sig_in;
  logic [31:0] a_out;
  logic [3:0] b_out;
  logic a_valid, a_ovf, a_gate, b_valid, b_ovf, b_gate;
  int checks = 0, failures = 0, shown = 0;
  int mode = 0, per = 10, gph = 0;
  freq_meter #(.GATE_CYCLES(1000)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_out(a_out), .freq_valid(a_valid), .overflow(a_ovf), .gate_active(a_gate));
  freq_meter #(.GATE_CYCLES(100), .COUNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .sig_in(sig_in),
    .freq_out(b_out), .freq_valid(b_valid), .overflow(b_ovf), .gate_active(b_gate));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      if (shown++ < 40) $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
    end
  endtask
  // Model: per instance, position in window (-1 idle, 0..G-1 gating, G publish cycle)
  int gl[2] = '{1000, 100};
  longint mx[2] = '{64'hFFFF_FFFF, 15};
  int ph[2] = '{-1, -1};
  longint cnt[2] = '{0, 0}, e_out[2] = '{0, 0};
  bit e_ovf[2] = '{0, 0}, e_val[2] = '{0, 0};
  bit hv[0:2] = '{0, 0, 0};
  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        ph[i] = -1; cnt[i] = 0; e_out[i] = 0; e_ovf[i] = 0; e_val[i] = 0;
      end
      hv = '{0, 0, 0};
    end else begin
      for (int i = 0; i < 2; i++) begin
        e_val[i] = 0;
        if (ph[i] < 0) begin
          if (enable) begin ph[i] = 0; cnt[i] = 0; end
        end else if (ph[i] < gl[i]) begin
          if (!enable) ph[i] = -1;
          else begin
            cnt[i] += longint'(hv[1] & ~hv[2]);
            if (ph[i] == gl[i] - 1) begin
              e_out[i] = cnt[i] > mx[i] ? mx[i] : cnt[i];
              e_ovf[i] = cnt[i] > mx[i];
              e_val[i] = 1;
              ph[i] = gl[i];
            end else ph[i]++;
          end
        end else begin
          ph[i] = enable ? 0 : -1;
          cnt[i] = 0;
        end
      end
      hv[2] = hv[1]; hv[1] = hv[0]; hv[0] = sig_in;
    end
  end
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(i ? "b_freq_out" : "a_freq_out", i ? longint'(b_out) : longint'(a_out), e_out[i]);
      chk(i ? "b_freq_valid" : "a_freq_valid", i ? longint'(b_valid) : longint'(a_valid), longint'(e_val[i]));
      chk(i ? "b_overflow" : "a_overflow", i ? longint'(b_ovf) : longint'(a_ovf), longint'(e_ovf[i]));
      chk(i ? "b_gate_active" : "a_gate_active", i ? longint'(b_gate) : longint'(a_gate),
          longint'(ph[i] >= 0 && ph[i] < gl[i]));
    end
  end
  logic [3:0] b_last = 0;
  logic b_lovf = 0;
  initial forever begin
    @(posedge clk);
    #1;
    if (b_valid) begin b_last = b_out; b_lovf = b_ovf; end
  end
  task automatic tick();
    @(negedge clk);
    if (mode == 1) begin
      gph = (gph + 1) % per;
      sig_in = gph < per / 2;
    end else if (mode == 2) sig_in = 1'($urandom_range(0, 1));
  endtask
  task automatic wait_valid(output int n);
    n = 0;
    do begin tick(); n++; end while (!a_valid && n < 5000);
    chk("valid_timeout", longint'(a_valid), 1);
  endtask
  task automatic run_period(input int p, input longint a_exp, input int b_exp, input bit b_ovf_exp, input bit do_b);
    int n;
    mode = 1; per = p;
    wait_valid(n);
    wait_valid(n);
    chk("spacing", n, 1001);
    chk("a_count", longint'(a_out), a_exp);
    chk("a_ovf", longint'(a_ovf), 0);
    if (do_b) begin
      tick();
      chk("b_count", longint'(b_last), b_exp);
      chk("b_ovf", longint'(b_lovf), longint'(b_ovf_exp));
    end
  endtask
  initial begin
    int n, nv;
    reset = 1; enable = 0; sig_in = 0;
    repeat (3) tick();
    chk("reset_out", longint'(a_out), 0);
    chk("reset_gate", longint'(a_gate), 0);
    reset = 0; enable = 1; mode = 1; per = 10;
    repeat (500) tick();
    #2 reset = 1;
    #1;
    chk("async_out", longint'(a_out), 0);
    chk("async_valid", longint'(a_valid), 0);
    chk("async_ovf", longint'(a_ovf), 0);
    chk("async_gate", longint'(a_gate), 0);
    chk("async_b_gate", longint'(b_gate), 0);
    tick(); tick();
    for (int k = 0; k < 20 && sig_in; k++) tick();
    reset = 0;
    wait_valid(n);
    chk("first_latency", n, 1001);
    chk("first_count", longint'(a_out), 100);
    run_period(10, 100, 10, 0, 1);
    run_period(4, 250, 15, 1, 1);
    run_period(20, 50, 5, 0, 1);
    run_period(250, 4, 0, 0, 0);
    mode = 0; sig_in = 0;
    wait_valid(n);
    wait_valid(n);
    repeat (998) tick();
    sig_in = 1;
    wait_valid(n);
    chk("edge_last_gate", longint'(a_out), 1);
    sig_in = 0;
    repeat (999) tick();
    sig_in = 1;
    wait_valid(n);
    chk("edge_latch_a", longint'(a_out), 0);
    wait_valid(n);
    chk("edge_latch_b", longint'(a_out), 0);
    run_period(10, 100, 10, 0, 1);
    repeat (500) tick();
    enable = 0;
    tick();
    chk("abort_gate", longint'(a_gate), 0);
    nv = 0;
    repeat (1500) begin tick(); if (a_valid) nv++; end
    chk("abort_no_valid", nv, 0);
    chk("abort_hold", longint'(a_out), 100);
    enable = 1;
    wait_valid(n);
    chk("reenable_latency", n, 1001);
    chk("reenable_count", longint'(a_out), 100);
    mode = 2;
    repeat (3) begin
      wait_valid(n);
      chk("fast_spacing", n, 1001);
    end
    repeat (6) begin
      mode = 1; per = $urandom_range(2, 60);
      wait_valid(n);
      wait_valid(n);
    end
    per = $urandom_range(2, 30);
    repeat (4000) begin
      tick();
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
